// File: rtl/iddmm_pkg.sv
// Shared types and constants for the IDDMM multiplier datapath.
package iddmm_pkg;

  localparam int unsigned LIMB_W      = 128;
  localparam int unsigned PROD_W      = 512;
  localparam int unsigned MUL_LAT_DEF = 6;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } mul_seq_state_t;

  // shift: 0 => x1, 1 => x2^128, 2 => x2^256
  typedef struct packed {
    logic       valid;
    logic [1:0] shift;
  } mul_tag_t;

endpackage

// File: rtl/iddmm_mul_128_to_256.sv
// Pipelined 128x128 -> 256 unsigned multiplier, LAT registers from operand sample to result.
module iddmm_mul_128_to_256 #(
  parameter int unsigned LAT = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] a,
  input  logic [127:0] b,
  output logic [255:0] result
);

  logic [255:0] r_pipe [LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= {128'b0, a} * {128'b0, b};
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign result = r_pipe[LAT-1];

endmodule

// File: rtl/iddmm_mul256_seq.sv
// Sequenced 256x256 -> 512 multiplier: issues four 128-bit limb products through the
// pipelined 128x128 multiplier and accumulates them under a tag pipe that tracks the shift.
module iddmm_mul256_seq
  import iddmm_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] result
);

  mul_seq_state_t r_state;
  logic [255:0]   r_a, r_b;
  logic [127:0]   r_mul_a, r_mul_b;
  logic [1:0]     r_idx, r_cnt;
  logic [511:0]   r_acc;
  logic           r_in_ready, r_out_valid;
  // Entry 0 sits beside the operand registers; entry MUL_LAT lines up with the product.
  mul_tag_t       r_tag [0:MUL_LAT];

  logic [255:0]   w_mul_res;
  logic [511:0]   w_addend;
  mul_tag_t       w_tag_out;

  iddmm_mul_128_to_256 #(
    .LAT (MUL_LAT)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (r_mul_a),
    .b      (r_mul_b),
    .result (w_mul_res)
  );

  assign w_tag_out = r_tag[MUL_LAT];

  always_comb begin
    w_addend = '0;
    case (w_tag_out.shift)
      2'd0:    w_addend = {256'b0, w_mul_res};
      2'd1:    w_addend = {128'b0, w_mul_res, 128'b0};
      2'd2:    w_addend = {w_mul_res, 256'b0};
      default: w_addend = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      for (int i = 0; i <= MUL_LAT; i++) r_tag[i] <= '0;
    end else begin
      for (int i = 1; i <= MUL_LAT; i++) r_tag[i] <= r_tag[i-1];
      r_tag[0] <= '0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;

      if (w_tag_out.valid) begin
        r_acc <= r_acc + w_addend;
        r_cnt <= r_cnt + 2'd1;
      end

      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_acc      <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= StIssue;
          end
        end
        StIssue: begin
          r_mul_a        <= r_idx[1] ? r_a[255:128] : r_a[127:0];
          r_mul_b        <= r_idx[0] ? r_b[255:128] : r_b[127:0];
          r_tag[0].valid <= 1'b1;
          r_tag[0].shift <= {1'b0, r_idx[1]} + {1'b0, r_idx[0]};
          r_idx          <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= StDrain;
        end
        StDrain: begin
          if (w_tag_out.valid && r_cnt == 2'd3) begin
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_acc;

endmodule

// File: tb/tb_iddmm_mul256_seq.sv
// Directed and random checks of the sequenced 256x256 multiplier.
module tb_iddmm_mul256_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] a;
  logic [255:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] result;

  int n_total = 0;
  int n_bad   = 0;

  iddmm_mul256_seq #(
    .MUL_LAT (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake at the next edge; returns #1 into cycle 0.
  task automatic start_op(input logic [255:0] ta, input logic [255:0] tb_v);
    int g;
    g = 0;
    while (!in_ready && g < 200) begin
      tick();
      g++;
    end
    if (!in_ready) check("in_ready_wait", {511'b0, in_ready}, 512'd1);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    tick();
    in_valid = 1'b0;
    a        = rand256();
    b        = rand256();
  endtask

  task automatic finish_op(input string tag, input logic [511:0] exp, input int stall,
                           input int exp_lat);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check({tag, "_valid"}, {511'b0, out_valid}, 512'd1);
    if (exp_lat >= 0) check({tag, "_lat"}, 512'(cyc), 512'(exp_lat));
    check(tag, result, exp);
    for (int i = 0; i < stall; i++) begin
      if (i == stall / 2) begin
        in_valid = 1'b1;
        a        = rand256();
        b        = rand256();
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check({tag, "_hold"}, result, exp);
      check({tag, "_hold_inrdy"}, {511'b0, in_ready}, 512'd0);
      check({tag, "_hold_ovld"}, {511'b0, out_valid}, 512'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_post_inrdy"}, {511'b0, in_ready}, 512'd1);
    check({tag, "_post_ovld"}, {511'b0, out_valid}, 512'd0);
  endtask

  initial begin
    logic [255:0] ra, rb;
    logic [511:0] e;
    logic         saw_valid;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_inrdy", {511'b0, in_ready}, 512'd1);
    check("rst_ovld", {511'b0, out_valid}, 512'd0);
    check("rst_result", result, 512'd0);

    start_op(256'd1, 256'd1);
    finish_op("one", 512'd1, 0, 11);

    start_op({256{1'b1}}, {256{1'b1}});
    e = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
    finish_op("allones", e, 0, 11);

    ra = 256'd1 << 128;
    start_op(ra, ra);
    e = 512'd1 << 256;
    finish_op("pow128", e, 0, -1);

    ra = (256'd1 << 128) + 256'd3;
    rb = (256'd5 << 128) + 256'd7;
    e  = (512'd5 << 256) + (512'd22 << 128) + 512'd21;
    start_op(ra, rb);
    finish_op("mixed", e, 0, -1);

    start_op(256'd6, 256'd7);
    finish_op("stall", 512'd42, 20, 11);
    start_op(256'd9, 256'd11);
    finish_op("after_stall", 512'd99, 0, 11);

    // Reset for one cycle during cycle 3 of an operation.
    start_op(256'd5, 256'd5);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_inrdy", {511'b0, in_ready}, 512'd1);
    check("midrst_ovld", {511'b0, out_valid}, 512'd0);
    tick();
    check("midrst_inrdy2", {511'b0, in_ready}, 512'd1);
    check("midrst_ovld2", {511'b0, out_valid}, 512'd0);
    saw_valid = 1'b0;
    repeat (15) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_quiet", {511'b0, saw_valid}, 512'd0);
    start_op(256'd2, 256'd3);
    finish_op("midrst_op", 512'd6, 0, 11);

    for (int n = 0; n < 1000; n++) begin
      ra = rand256();
      rb = rand256();
      if (n % 10 == 0) ra = {256{1'b1}};
      e = {256'b0, ra} * {256'b0, rb};
      start_op(ra, rb);
      finish_op("rand", e, int'($urandom_range(0, 3)), 11);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
